// File: rtl/synaptic_accumulator.sv
// Synaptic input stage of the LIF membrane datapath: sums the stored signed weights
// of every spiking input line, one synapse per clock, saturating after each add.
module synaptic_accumulator #(
  parameter int n_stage     = 6,
  parameter int N_INPUTS    = 8,
  parameter int WEIGHT_BITS = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   weight_load,
  input  logic [WEIGHT_BITS-1:0] weight_in,
  input  logic [N_INPUTS-1:0]    spikes_in,
  input  logic                   start,
  output logic                   busy,
  output logic                   sum_valid,
  output logic [n_stage+1:0]     sum
);

  localparam int SW = n_stage + 2;
  localparam int AW = SW + 1;
  localparam int IW = $clog2(N_INPUTS);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                  state_reg;
  logic [WEIGHT_BITS-1:0]  w_reg  [N_INPUTS];
  logic [WEIGHT_BITS-1:0]  w_next [N_INPUTS];
  logic [N_INPUTS-1:0]     spikes_reg;
  logic [IW-1:0]           index_reg;
  logic [SW-1:0]           acc_reg;
  logic [SW-1:0]           sum_reg;
  logic                    busy_reg;
  logic                    sum_valid_reg;

  logic [WEIGHT_BITS-1:0]  w_sel;
  logic [AW-1:0]           add_full;
  logic [SW-1:0]           acc_next;
  logic                    last_index;
  logic                    load_en;

  // Weight store is a shift chain: the newest weight enters at the top index.
  generate
    for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_wshift
      if (gi == N_INPUTS - 1) begin : g_tail
        assign w_next[gi] = weight_in;
      end else begin : g_body
        assign w_next[gi] = w_reg[gi+1];
      end
    end
  endgenerate

  assign load_en = weight_load && !busy_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_INPUTS; i++) w_reg[i] <= '0;
    end else if (load_en) begin
      w_reg <= w_next;
    end
  end

  assign w_sel      = w_reg[index_reg];
  assign last_index = (index_reg == IW'(N_INPUTS - 1));
  assign add_full   = {acc_reg[SW-1], acc_reg}
                    + {{(AW-WEIGHT_BITS){w_sel[WEIGHT_BITS-1]}}, w_sel};

  // One guard bit suffices: overflow shows up as the top two bits disagreeing.
  always_comb begin
    acc_next = acc_reg;
    if (spikes_reg[index_reg]) begin
      if (add_full[AW-1] != add_full[AW-2])
        acc_next = add_full[AW-1] ? {1'b1, {(SW-1){1'b0}}} : {1'b0, {(SW-1){1'b1}}};
      else
        acc_next = add_full[SW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      busy_reg      <= 1'b0;
      sum_valid_reg <= 1'b0;
      sum_reg       <= '0;
      acc_reg       <= '0;
      index_reg     <= '0;
      spikes_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          sum_valid_reg <= 1'b0;
          if (start) begin
            spikes_reg <= spikes_in;
            acc_reg    <= '0;
            index_reg  <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= ACCUM;
          end else begin
            state_reg  <= IDLE;
          end
        end
        ACCUM: begin
          acc_reg <= acc_next;
          if (last_index) begin
            state_reg     <= DONE;
            sum_reg       <= acc_next;
            sum_valid_reg <= 1'b1;
            busy_reg      <= 1'b0;
          end else begin
            index_reg <= index_reg + IW'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy      = busy_reg;
  assign sum_valid = sum_valid_reg;
  assign sum       = sum_reg;

endmodule

// File: tb/tb_synaptic_accumulator.sv
// Randomized scoreboard bench for synaptic_accumulator: a driver pushes expected
// results, a negedge monitor pops and checks them along with busy and sum hold.
module tb_synaptic_accumulator;

  localparam int n_stage     = 6;
  localparam int N_INPUTS    = 8;
  localparam int WEIGHT_BITS = 8;
  localparam int SW          = n_stage + 2;
  localparam int SUM_MAX     = (1 << (SW - 1)) - 1;
  localparam int SUM_MIN     = -(1 << (SW - 1));

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   weight_load;
  logic [WEIGHT_BITS-1:0] weight_in;
  logic [N_INPUTS-1:0]    spikes_in;
  logic                   start;
  logic                   busy;
  logic                   sum_valid;
  logic signed [SW-1:0]   sum;

  synaptic_accumulator #(
    .n_stage(n_stage), .N_INPUTS(N_INPUTS), .WEIGHT_BITS(WEIGHT_BITS)
  ) dut (
    .clk(clk), .reset(reset), .weight_load(weight_load), .weight_in(weight_in),
    .spikes_in(spikes_in), .start(start), .busy(busy), .sum_valid(sum_valid), .sum(sum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int sum; int due; } exp_t;
  exp_t q[$];
  int   wq[$];          // reference weight store, front = w[0]
  int   hold_sum = 0;
  int   last_e0  = -1000;
  bit   mon_en   = 1'b0;
  int   n_vec    = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_sum(input logic [N_INPUTS-1:0] sp);
    int acc = 0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (sp[i]) begin
        acc = acc + wq[i];
        if (acc > SUM_MAX) acc = SUM_MAX;
        if (acc < SUM_MIN) acc = SUM_MIN;
      end
    end
    return acc;
  endfunction

  // A load is taken unless the capturing edge falls inside an accumulation window.
  function automatic bit dut_busy_at_edge(input int e);
    return (e > last_e0) && (e <= last_e0 + N_INPUTS);
  endfunction

  task automatic drive_cycle(input bit st, input bit wl, input int w, input logic [N_INPUTS-1:0] sp);
    start = st; weight_load = wl; weight_in = WEIGHT_BITS'(w); spikes_in = sp;
    if (wl && !dut_busy_at_edge(cyc + 1)) begin
      void'(wq.pop_front());
      wq.push_back(w);
    end
    tick();
    start = 1'b0; weight_load = 1'b0;
  endtask

  task automatic load_weight(input int w);
    drive_cycle(1'b0, 1'b1, w, spikes_in);
  endtask

  task automatic do_start(input logic [N_INPUTS-1:0] sp);
    exp_t e;
    e.sum = ref_sum(sp);
    e.due = cyc + 1 + N_INPUTS;
    q.push_back(e);
    last_e0 = cyc + 1;
    start = 1'b1; spikes_in = sp;
    tick();
    start = 1'b0; spikes_in = N_INPUTS'($urandom);
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && q.size() > 0; k++) tick();
    chk("drain", q.size(), 0);
    tick();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q.delete();
    hold_sum = 0;
    last_e0 = -1000;
    wq.delete();
    for (int i = 0; i < N_INPUTS; i++) wq.push_back(0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      bit exp_busy;
      exp_t e;
      if (q.size() > 0 && cyc > q[0].due) begin
        chk("missing_valid", 0, 1);
        void'(q.pop_front());
      end
      exp_busy = (q.size() > 0) && (cyc >= q[0].due - N_INPUTS) && (cyc < q[0].due);
      chk("busy", int'(busy), int'(exp_busy));
      if (sum_valid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", 1, 0);
        end else begin
          e = q.pop_front();
          chk("valid_cycle", cyc, e.due);
          chk("sum", int'(sum), e.sum);
          hold_sum = e.sum;
        end
      end else begin
        chk("sum_hold", int'(sum), hold_sum);
      end
    end
  end

  initial begin
    reset = 1'b1; weight_load = 1'b0; weight_in = '0; spikes_in = '0; start = 1'b0;
    for (int i = 0; i < N_INPUTS; i++) wq.push_back(0);
    repeat (3) tick();
    chk("reset_busy", int'(busy), 0);
    chk("reset_valid", int'(sum_valid), 0);
    chk("reset_sum", int'(sum), 0);
    reset = 1'b0;
    mon_en = 1'b1;

    // Ascending weights, two spikes
    for (int i = 1; i <= N_INPUTS; i++) load_weight(i);
    do_start(8'b0000_0101);
    drain();

    // Positive and negative saturation
    for (int i = 0; i < N_INPUTS; i++) load_weight(127);
    do_start(8'hFF);
    drain();
    for (int i = 0; i < N_INPUTS; i++) load_weight(-128);
    do_start(8'hFF);
    drain();
    load_weight(-128); load_weight(100);
    for (int i = 2; i < N_INPUTS; i++) load_weight(0);
    do_start(8'h03);
    drain();

    // No spikes, then a back-to-back start issued in the DONE cycle
    do_start(8'h00);
    for (int k = 0; k < 50 && !(q.size() > 0 && cyc == q[0].due); k++) tick();
    chk("reach_done", int'(q.size() > 0 && cyc == q[0].due), 1);
    do_start(N_INPUTS'($urandom));
    drain();

    // start / weight_load / spikes_in disturbances during accumulation
    for (int i = 0; i < N_INPUTS; i++) load_weight(int'($urandom_range(0, 255)) - 128);
    do_start(8'hA5);
    for (int k = 0; k < 5; k++)
      drive_cycle(1'b1, 1'b1, int'($urandom_range(0, 255)) - 128, N_INPUTS'($urandom));
    drain();
    do_start(8'hA5);
    drain();

    // Reset in the 4th accumulation cycle aborts and clears weights
    for (int i = 0; i < N_INPUTS; i++) load_weight(int'($urandom_range(1, 127)));
    do_start(8'hFF);
    repeat (3) tick();
    apply_reset();
    tick();
    do_start(8'hFF);
    drain();

    // Randomized timesteps, some back-to-back
    for (int t = 0; t < 20; t++) begin
      int nl = $urandom_range(0, N_INPUTS);
      for (int i = 0; i < nl; i++) load_weight(int'($urandom_range(0, 255)) - 128);
      do_start(N_INPUTS'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 50 && !(q.size() > 0 && cyc == q[0].due); k++) tick();
        do_start(N_INPUTS'($urandom));
      end
      drain();
    end

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
